mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 192 +++++++++++++++++++
 tb/tb_mem_access.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory stage of a small RISC-V style pipeline.
// It decodes load and store instructions, issues a single data-memory
// request, waits for the acknowledge or a timeout, and extracts and extends
// the load result for write-back.
//
// Ports
//   clk, reset               single clock; synchronous active-high reset
//   start_i                  one-cycle pulse: instruction entered the stage
//   ir_i, addr_i, rs2_i      instruction, effective address, store data
//                            (held stable from start_i until done_o)
//   mem_o                    extended load result
//   wd_q_readin_o, done_o    one-cycle completion strobes (coincident)
//   busy_o                   stage occupied (REQ or DONE)
//   fault_o                  misalign / illegal funct3 / ack timeout
//   dmem_req_o, dmem_we_o    data-memory request and write enable
//   dmem_addr_o, dmem_be_o   word address and byte enables
//   dmem_wdata_o             lane-replicated store data
//   dmem_rdata_i, dmem_ack_i read data and acknowledge from data memory
module mem_access #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] mem_o,
  output logic        wd_q_readin_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        fault_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Last count value before the timeout fires.
  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic       load_q;

  // Decode of the incoming instruction.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store, legal, misalign;
  logic [3:0] be_c;
  logic [31:0] wdata_c;

  assign opcode   = ir_i[6:0];
  assign funct3   = ir_i[14:12];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);

  // Bits of the instruction word this stage has no use for.
  logic unused_ir;
  assign unused_ir = ^{ir_i[31:15], ir_i[11:7]};

  always_comb begin
    legal = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end else if (is_store) begin
      legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
    end
  end

  // funct3[1:0] encodes access size for every legal load/store.
  assign misalign = ((funct3[1:0] == 2'b01) && addr_i[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = rs2_i;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_i[1:0];
        wdata_c = {4{rs2_i[7:0]}};
      end
      2'b01: begin
        be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{rs2_i[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = rs2_i;
      end
    endcase
  end

  // Load extraction uses the size/offset captured when the request started.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign byte_sel = dmem_rdata_i[8*off_q +: 8];
  assign half_sel = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = dmem_rdata_i;
    endcase
  end

  assign busy_o        = (state != S_IDLE);
  assign done_o        = (state == S_DONE);
  assign wd_q_readin_o = (state == S_DONE);
  assign dmem_req_o    = (state == S_REQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      mem_o        <= 32'd0;
      fault_o      <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_be_o    <= 4'd0;
      dmem_addr_o  <= 32'd0;
      dmem_wdata_o <= 32'd0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      load_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            fault_o <= 1'b0;
            if (is_load || is_store) begin
              if (!legal || misalign) begin
                fault_o <= 1'b1;
                state   <= S_DONE;
              end else begin
                state        <= S_REQ;
                cnt          <= 8'd0;
                dmem_we_o    <= is_store;
                dmem_be_o    <= be_c;
                dmem_addr_o  <= {addr_i[31:2], 2'b00};
                dmem_wdata_o <= wdata_c;
                f3_q         <= funct3;
                off_q        <= addr_i[1:0];
                load_q       <= is_load;
              end
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_REQ: begin
          // Ack takes priority over a timeout on the same edge.
          if (dmem_ack_i) begin
            state     <= S_DONE;
            dmem_we_o <= 1'b0;
            dmem_be_o <= 4'd0;
            if (load_q) mem_o <= load_data;
          end else if (cnt == CNT_LAST) begin
            state     <= S_DONE;
            fault_o   <= 1'b1;
            dmem_we_o <= 1'b0;
            dmem_be_o <= 4'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  localparam int TO = 16;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] ir_i = '0, addr_i = '0, rs2_i = '0, dmem_rdata_i = '0;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] mem_o, dmem_addr_o, dmem_wdata_o;
  logic        wd_q_readin_o, done_o, busy_o, fault_o, dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;

  mem_access #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .ir_i(ir_i), .addr_i(addr_i),
    .rs2_i(rs2_i), .mem_o(mem_o), .wd_q_readin_o(wd_q_readin_o), .done_o(done_o),
    .busy_o(busy_o), .fault_o(fault_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  // Transaction-level model: what the stage must be doing this cycle.
  bit          started = 0;
  bit          m_inreq = 0, m_done = 0, m_fault = 0, m_load = 0, m_we = 0;
  int          m_wait = 0;
  logic [2:0]  m_f3 = 0;
  logic [31:0] m_addr = 0, m_wd = 0, m_mem = 0;
  logic [3:0]  m_be = 0;

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (rd >> (8 * a[1:0])) & 32'hFF;
        if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (rd >> (16 * a[1])) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    logic [6:0] op;
    logic [2:0] f3;
    bit ok, mis;
    started = 1;
    if (reset) begin
      m_inreq = 0; m_done = 0; m_fault = 0; m_mem = 0; m_wait = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_inreq) begin
      if (dmem_ack_i) begin
        m_inreq = 0; m_done = 1;
        if (m_load) m_mem = extract(m_f3, m_addr, dmem_rdata_i);
      end else begin
        m_wait++;
        if (m_wait == TO) begin m_inreq = 0; m_done = 1; m_fault = 1; end
      end
    end else if (start_i) begin
      op = ir_i[6:0];
      f3 = ir_i[14:12];
      m_fault = 0;
      if (op == LOAD || op == STORE) begin
        ok  = (op == LOAD) ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
        mis = (f3[1:0] == 1 && addr_i[0]) || (f3[1:0] == 2 && addr_i[1:0] != 0);
        if (!ok || mis) begin
          m_fault = 1; m_done = 1;
        end else begin
          m_inreq = 1; m_wait = 0; m_load = (op == LOAD); m_we = (op == STORE);
          m_f3 = f3; m_addr = addr_i;
          if (f3[1:0] == 0) begin
            m_be = 4'(1 << addr_i[1:0]); m_wd = {24'd0, rs2_i[7:0]} * 32'h0101_0101;
          end else if (f3[1:0] == 1) begin
            m_be = addr_i[1] ? 4'd12 : 4'd3; m_wd = {16'd0, rs2_i[15:0]} * 32'h0001_0001;
          end else begin
            m_be = 4'd15; m_wd = rs2_i;
          end
        end
      end else begin
        m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("req", dmem_req_o, m_inreq);
      chk("done", done_o, m_done);
      chk("wdq", wd_q_readin_o, m_done);
      chk("busy", busy_o, m_inreq | m_done);
      chk("fault", fault_o, m_fault);
      chk("mem", mem_o, m_mem);
      if (m_inreq) begin
        chk("we", dmem_we_o, m_we);
        chk("be", dmem_be_o, m_be);
        chk("addr", dmem_addr_o, {m_addr[31:2], 2'b00});
        chk("wdata", dmem_wdata_o, m_wd);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic go(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] d);
    ir_i = ir; addr_i = a; rs2_i = d; start_i = 1; tick(); start_i = 0;
  endtask

  task automatic ack(input logic [31:0] rd);
    dmem_rdata_i = rd; dmem_ack_i = 1; tick(); dmem_ack_i = 0;
  endtask

  initial begin
    int n;
    tick(); tick();
    chk("rst_busy", busy_o, 0); chk("rst_mem", mem_o, 0); chk("rst_req", dmem_req_o, 0);
    chk("rst_we", dmem_we_o, 0); chk("rst_be", dmem_be_o, 0); chk("rst_done", done_o, 0);
    chk("rst_fault", fault_o, 0);
    reset = 0; tick();

    // LB at 0x103, ack after 3 request cycles.
    go(mk(LOAD, 3'b000), 32'h103, 0);
    chk("lb_be", dmem_be_o, 4'b1000); chk("lb_addr", dmem_addr_o, 32'h100);
    tick(); tick();
    ack(32'h80FF_0000);
    chk("lb_done", done_o, 1); chk("lb_mem", mem_o, 32'hFFFF_FF80);
    tick();
    chk("lb_single", done_o, 0);

    // LHU at 0x202, then misaligned LW at 0x202.
    go(mk(LOAD, 3'b101), 32'h202, 0);
    chk("lhu_be", dmem_be_o, 4'b1100);
    ack(32'h8001_1234);
    chk("lhu_mem", mem_o, 32'h0000_8001);
    tick();
    go(mk(LOAD, 3'b010), 32'h202, 0);
    chk("lw_mis_req", dmem_req_o, 0); chk("lw_mis_fault", fault_o, 1); chk("lw_mis_done", done_o, 1);
    tick();

    // SB at 0x001.
    go(mk(STORE, 3'b000), 32'h001, 32'h1234_56AB);
    chk("sb_we", dmem_we_o, 1); chk("sb_be", dmem_be_o, 4'b0010);
    chk("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB); chk("sb_fault", fault_o, 0);
    ack(32'hFFFF_FFFF);
    chk("sb_mem", mem_o, 32'h0000_8001);
    tick();

    // Non-memory opcode.
    go(mk(ALU, 3'b000), 32'h0, 0);
    chk("add_done", done_o, 1); chk("add_req", dmem_req_o, 0); chk("add_mem", mem_o, 32'h0000_8001);
    tick();

    // Illegal funct3 for load and store; SH misaligned.
    go(mk(LOAD, 3'b011), 32'h0, 0); chk("ill_ld_fault", fault_o, 1); tick();
    go(mk(STORE, 3'b100), 32'h0, 0); chk("ill_st_fault", fault_o, 1); tick();
    go(mk(STORE, 3'b001), 32'h3, 0); chk("sh_mis_fault", fault_o, 1); tick();

    // SH at 0x002, LH at 0x006, LBU at 0x011.
    go(mk(STORE, 3'b001), 32'h2, 32'hCAFE_BEEF);
    chk("sh_be", dmem_be_o, 4'b1100); chk("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
    ack(0); tick();
    go(mk(LOAD, 3'b001), 32'h6, 0); ack(32'h9ABC_0000);
    chk("lh_mem", mem_o, 32'hFFFF_9ABC); tick();
    go(mk(LOAD, 3'b100), 32'h11, 0); ack(32'h0000_F200);
    chk("lbu_mem", mem_o, 32'h0000_00F2); tick();

    // LW with no ack: request must stay up exactly TO cycles.
    go(mk(LOAD, 3'b010), 32'h300, 0);
    n = 0;
    while (dmem_req_o && n < 40) begin n++; tick(); end
    chk("to_cycles", n, TO); chk("to_fault", fault_o, 1); chk("to_done", done_o, 1);
    tick();

    // Ack on the edge where the counter would hit the limit: ack wins.
    go(mk(LOAD, 3'b010), 32'h404, 0);
    repeat (TO - 1) tick();
    ack(32'h1122_3344);
    chk("edge_fault", fault_o, 0); chk("edge_done", done_o, 1); chk("edge_mem", mem_o, 32'h1122_3344);
    tick();

    // Second start during REQ and start during DONE are ignored.
    go(mk(LOAD, 3'b010), 32'h408, 0);
    start_i = 1; tick(); start_i = 0;
    ack(32'hA5A5_A5A5);
    chk("ign_mem", mem_o, 32'hA5A5_A5A5);
    start_i = 1; tick(); start_i = 0;
    chk("ign_busy", busy_o, 0);

    // Ack outside REQ is ignored.
    dmem_rdata_i = 32'hDEAD_BEEF; dmem_ack_i = 1; tick(); tick(); dmem_ack_i = 0;
    chk("stray_mem", mem_o, 32'hA5A5_A5A5); chk("stray_done", done_o, 0);

    // Reset while in REQ, late ack afterwards.
    go(mk(LOAD, 3'b010), 32'h500, 0);
    tick();
    reset = 1; tick(); reset = 0;
    chk("mid_req", dmem_req_o, 0); chk("mid_busy", busy_o, 0); chk("mid_mem", mem_o, 0);
    chk("mid_be", dmem_be_o, 0);
    ack(32'h7777_7777);
    chk("mid_done", done_o, 0); chk("mid_mem2", mem_o, 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end
endmodule
